// File: rtl/mem_access_sequencer.sv
// Request sequencer in front of the 3-to-8 row decoder of the 8x8-bit memory array.
// Define MEM_ACCESS_SEQUENCER_ACCESS_COUNT_EN to add the saturating o_access_count output.
module mem_access_sequencer #(
   parameter int ACCESS_CYCLES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_req_valid,
   output logic       o_req_ready,
   input  logic       i_write,
   input  logic [2:0] i_address,
   input  logic [7:0] i_wdata,
   output logic [2:0] o_k_address,
   output logic       o_valid,
   output logic       o_write_en,
   output logic       o_read_en,
   output logic [7:0] o_wdata,
   input  logic [7:0] i_rdata,
   output logic       o_rsp_valid,
   output logic [7:0] o_rdata,
   input  logic       i_rsp_ready,
`ifdef MEM_ACCESS_SEQUENCER_ACCESS_COUNT_EN
   output logic [7:0] o_access_count,
`endif
   output logic [1:0] dbg_state
);

   // Handshakes (request and response): a transfer happens on a rising edge where valid and
   // ready are both high; the source holds valid and payload stable until that edge.

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } state_t;

   localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

   state_t     state;
   logic [3:0] cnt;
   logic       write_q;

   assign dbg_state = state;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         write_q     <= 1'b0;
         o_req_ready <= 1'b1;
         o_k_address <= '0;
         o_wdata     <= '0;
         o_valid     <= 1'b0;
         o_write_en  <= 1'b0;
         o_read_en   <= 1'b0;
         o_rsp_valid <= 1'b0;
         o_rdata     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (i_req_valid && o_req_ready) begin
                  write_q     <= i_write;
                  o_k_address <= i_address;
                  o_wdata     <= i_wdata;
                  o_req_ready <= 1'b0;
                  state       <= SETUP;
               end
            end
            // One dead cycle lets the address settle before the decoder is enabled.
            SETUP: begin
               state      <= ACCESS;
               cnt        <= CNT_LOAD;
               o_valid    <= 1'b1;
               o_write_en <= write_q;
               o_read_en  <= !write_q;
            end
            ACCESS: begin
               if (cnt == 4'd0) begin
                  o_valid    <= 1'b0;
                  o_write_en <= 1'b0;
                  o_read_en  <= 1'b0;
                  if (write_q) begin
                     state       <= IDLE;
                     o_req_ready <= 1'b1;
                  end else begin
                     state       <= RESP;
                     o_rdata     <= i_rdata;
                     o_rsp_valid <= 1'b1;
                  end
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            RESP: begin
               if (i_rsp_ready) begin
                  state       <= IDLE;
                  o_rsp_valid <= 1'b0;
                  o_req_ready <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef MEM_ACCESS_SEQUENCER_ACCESS_COUNT_EN
   logic [7:0] access_count_q;

   // Counts on the final ACCESS edge only, so a reset during ACCESS never counts.
   always_ff @(posedge clk) begin
      if (rst) begin
         access_count_q <= '0;
      end else if (state == ACCESS && cnt == 4'd0 && access_count_q != 8'hFF) begin
         access_count_q <= access_count_q + 8'd1;
      end
   end

   assign o_access_count = access_count_q;
`endif

   // Strobe sanity: never both strobes, never a strobe without the decoder enabled.
   assert property (@(posedge clk) disable iff (rst) !(o_write_en && o_read_en));
   assert property (@(posedge clk) disable iff (rst) (o_write_en || o_read_en) |-> o_valid);
   assert property (@(posedge clk) disable iff (rst) !(o_req_ready && (o_valid || o_rsp_valid)));

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Bench for mem_access_sequencer: three instances (ACCESS_CYCLES = 2, 1, 15) against a
// cycle-count reference model, a directed vector table, hand sequences and random traffic.
`timescale 1ns/1ps
module tb_mem_access_sequencer;
  localparam int N = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       req_valid [N];
  logic       req_ready [N];
  logic       write_s   [N];
  logic [2:0] addr_s    [N];
  logic [7:0] wdata_s   [N];
  logic [2:0] k_address [N];
  logic       valid     [N];
  logic       write_en  [N];
  logic       read_en   [N];
  logic [7:0] wdata_o   [N];
  logic [7:0] rdata_i   [N];
  logic       rsp_valid [N];
  logic [7:0] rdata_o   [N];
  logic       rsp_ready [N];
  logic [1:0] dbg       [N];
`ifdef MEM_ACCESS_SEQUENCER_ACCESS_COUNT_EN
  logic [7:0] acc_cnt   [N];
`endif
  logic [7:0] mem [N][8];

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  bit chk_en = 0;

  function automatic int ac_of(input int k);
    return (k == 0) ? 2 : (k == 1) ? 1 : 15;
  endfunction

  function automatic logic [7:0] init_val(input int i);
    return (i == 3) ? 8'h3C : 8'(16 * i + 5);
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_dut
    assign rdata_i[g] = mem[g][k_address[g]];
    mem_access_sequencer #(.ACCESS_CYCLES((g == 0) ? 2 : (g == 1) ? 1 : 15)) dut (
      .clk(clk), .rst(rst),
      .i_req_valid(req_valid[g]), .o_req_ready(req_ready[g]),
      .i_write(write_s[g]), .i_address(addr_s[g]), .i_wdata(wdata_s[g]),
      .o_k_address(k_address[g]), .o_valid(valid[g]),
      .o_write_en(write_en[g]), .o_read_en(read_en[g]), .o_wdata(wdata_o[g]),
      .i_rdata(rdata_i[g]),
      .o_rsp_valid(rsp_valid[g]), .o_rdata(rdata_o[g]), .i_rsp_ready(rsp_ready[g]),
`ifdef MEM_ACCESS_SEQUENCER_ACCESS_COUNT_EN
      .o_access_count(acc_cnt[g]),
`endif
      .dbg_state(dbg[g])
    );
  end

  // Reference model: a transaction accepted at edge t keeps the decoder enabled for
  // edges t+1 .. t+AC and finishes at edge t+AC+1.
  bit         m_busy [N];
  bit         m_resp [N];
  int         m_t    [N];
  bit         m_wr   [N];
  logic [2:0] m_addr [N];
  logic [7:0] m_wd   [N];
  logic [7:0] m_rd   [N];
  int         m_cnt  [N];

  always @(posedge clk) begin
    cyc++;
    for (int k = 0; k < N; k++) begin
      if (!rst && write_en[k]) mem[k][k_address[k]] = wdata_o[k];
      if (rst) begin
        m_busy[k] = 0; m_resp[k] = 0; m_rd[k] = 0; m_addr[k] = 0; m_wd[k] = 0;
        m_wr[k] = 0; m_cnt[k] = 0;
      end else if (m_busy[k]) begin
        if (cyc - m_t[k] == ac_of(k) + 1) begin
          m_busy[k] = 0;
          if (m_cnt[k] < 255) m_cnt[k]++;
          if (!m_wr[k]) begin
            m_resp[k] = 1;
            m_rd[k] = mem[k][m_addr[k]];
          end
        end
      end else if (m_resp[k]) begin
        if (rsp_ready[k]) m_resp[k] = 0;
      end else if (req_valid[k]) begin
        m_busy[k] = 1; m_t[k] = cyc; m_wr[k] = write_s[k];
        m_addr[k] = addr_s[k]; m_wd[k] = wdata_s[k];
      end
    end
  end

  task automatic check(input string name, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d cycle %0d: got %0h expected %0h", name, k, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin : chk_blk
    bit ev;
    if (chk_en) begin
      for (int k = 0; k < N; k++) begin
        ev = m_busy[k] && (cyc - m_t[k] >= 1);
        check("req_ready", k, 32'(req_ready[k]), 32'(!m_busy[k] && !m_resp[k]));
        check("valid", k, 32'(valid[k]), 32'(ev));
        check("write_en", k, 32'(write_en[k]), 32'(ev && m_wr[k]));
        check("read_en", k, 32'(read_en[k]), 32'(ev && !m_wr[k]));
        check("rsp_valid", k, 32'(rsp_valid[k]), 32'(m_resp[k]));
        check("rdata", k, 32'(rdata_o[k]), 32'(m_rd[k]));
        check("k_address", k, 32'(k_address[k]), 32'(m_addr[k]));
        check("wdata", k, 32'(wdata_o[k]), 32'(m_wd[k]));
`ifdef MEM_ACCESS_SEQUENCER_ACCESS_COUNT_EN
        check("access_count", k, 32'(acc_cnt[k]), 32'(m_cnt[k]));
`endif
      end
    end
  end

  // Driver tasks: inputs change on the falling edge only.
  task automatic issue(input int k, input bit wr, input logic [2:0] a, input logic [7:0] d);
    bit acc = 0;
    @(negedge clk);
    req_valid[k] = 1; write_s[k] = wr; addr_s[k] = a; wdata_s[k] = d;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      if (req_ready[k]) begin acc = 1; break; end
    end
    check("accept", k, 32'(acc), 32'd1);
    @(negedge clk);
    req_valid[k] = 0;
  endtask

  task automatic wait_for(input int k, input bit want_rsp, input string name);
    bit done = 0;
    for (int i = 0; i < 60; i++) begin
      if (want_rsp ? rsp_valid[k] : req_ready[k]) begin done = 1; break; end
      @(negedge clk);
    end
    check(name, k, 32'(done), 32'd1);
  endtask

  typedef struct {
    int         k;
    bit         wr;
    logic [2:0] a;
    logic [7:0] d;
    int         hold;
    logic [7:0] exp_sel;
    int         exp_nval;
    logic [7:0] exp_rd;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] sh [N][8];

  function automatic void add_vec(input int k, input bit wr, input logic [2:0] a,
                                  input logic [7:0] d, input int hold);
    vec_t v;
    v.k = k; v.wr = wr; v.a = a; v.d = d; v.hold = hold;
    v.exp_sel = 8'h01 << a;
    v.exp_nval = ac_of(k);
    v.exp_rd = wr ? 8'h00 : sh[k][a];
    if (wr) sh[k][a] = d;
    vecs.push_back(v);
  endfunction

  task automatic run_vec(input vec_t v);
    int nval = 0;
    int lat = -1;
    logic [7:0] sel = 8'h00;
    issue(v.k, v.wr, v.a, v.d);
    for (int i = 0; i < 40; i++) begin
      if (valid[v.k]) begin nval++; sel |= 8'h01 << k_address[v.k]; end
      if (v.wr ? req_ready[v.k] : rsp_valid[v.k]) begin lat = i; break; end
      @(negedge clk);
    end
    check("latency", v.k, 32'(lat), 32'(ac_of(v.k) + 1));
    check("valid_cycles", v.k, 32'(nval), 32'(v.exp_nval));
    check("select", v.k, 32'(sel), 32'(v.exp_sel));
    if (!v.wr) begin
      for (int h = 0; h < v.hold; h++) begin
        check("stall_rsp_valid", v.k, 32'(rsp_valid[v.k]), 32'd1);
        check("stall_rdata", v.k, 32'(rdata_o[v.k]), 32'(v.exp_rd));
        @(negedge clk);
      end
      check("rsp_rdata", v.k, 32'(rdata_o[v.k]), 32'(v.exp_rd));
      rsp_ready[v.k] = 1;
      @(negedge clk);
      rsp_ready[v.k] = 0;
      check("rsp_drop", v.k, 32'(rsp_valid[v.k]), 32'd0);
      check("ready_back", v.k, 32'(req_ready[v.k]), 32'd1);
    end
  endtask

  initial begin
    rst = 1;
    for (int k = 0; k < N; k++) begin
      req_valid[k] = 0; write_s[k] = 0; addr_s[k] = 0; wdata_s[k] = 0; rsp_ready[k] = 0;
      for (int i = 0; i < 8; i++) begin
        mem[k][i] = init_val(i);
        sh[k][i] = init_val(i);
      end
    end

    add_vec(0, 1, 3'd5, 8'hA5, 0);
    add_vec(0, 0, 3'd3, 8'h00, 0);
    add_vec(0, 0, 3'd5, 8'h00, 3);
    add_vec(1, 1, 3'd0, 8'h5A, 0);
    add_vec(1, 0, 3'd0, 8'h00, 1);
    add_vec(2, 1, 3'd7, 8'hC3, 0);
    add_vec(2, 0, 3'd7, 8'h00, 2);
    for (int a = 0; a < 8; a++) begin
      add_vec(1, 0, 3'(a), 8'h00, 0);
      add_vec(2, 0, 3'(a), 8'h00, 0);
    end

    repeat (3) @(negedge clk);
    rst = 0;
    chk_en = 1;
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      check("reset_req_ready", k, 32'(req_ready[k]), 32'd1);
      check("reset_valid", k, 32'(valid[k]), 32'd0);
      check("reset_rsp_valid", k, 32'(rsp_valid[k]), 32'd0);
    end

    foreach (vecs[i]) run_vec(vecs[i]);

    // Back-pressure: response stalled 3 cycles while a new request waits.
    issue(0, 0, 3'd3, 8'h00);
    wait_for(0, 1, "bp_rsp");
    req_valid[0] = 1; write_s[0] = 1; addr_s[0] = 3'd2; wdata_s[0] = 8'h77;
    for (int h = 0; h < 3; h++) begin
      check("bp_req_ready", 0, 32'(req_ready[0]), 32'd0);
      check("bp_rsp_valid", 0, 32'(rsp_valid[0]), 32'd1);
      check("bp_rdata", 0, 32'(rdata_o[0]), 32'h3C);
      @(negedge clk);
    end
    rsp_ready[0] = 1;
    @(negedge clk);
    rsp_ready[0] = 0;
    check("bp_exit_rsp", 0, 32'(rsp_valid[0]), 32'd0);
    check("bp_exit_ready", 0, 32'(req_ready[0]), 32'd1);
    @(negedge clk);
    req_valid[0] = 0;
    check("bp_late_accept", 0, 32'(req_ready[0]), 32'd0);
    check("bp_late_addr", 0, 32'(k_address[0]), 32'd2);
    wait_for(0, 0, "bp_write_done");

    // Reset in the first ACCESS cycle of a write, then of a read.
    issue(0, 1, 3'd6, 8'h99);
    @(negedge clk);
    check("abort_w_active", 0, 32'(valid[0]), 32'd1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    check("abort_w_valid", 0, 32'(valid[0]), 32'd0);
    check("abort_w_wen", 0, 32'(write_en[0]), 32'd0);
    check("abort_w_ready", 0, 32'(req_ready[0]), 32'd1);
    check("abort_w_rsp", 0, 32'(rsp_valid[0]), 32'd0);
    issue(0, 0, 3'd4, 8'h00);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    check("abort_r_ren", 0, 32'(read_en[0]), 32'd0);
    check("abort_r_rdata", 0, 32'(rdata_o[0]), 32'd0);
    repeat (6) @(negedge clk);
    check("abort_r_no_rsp", 0, 32'(rsp_valid[0]), 32'd0);

`ifdef MEM_ACCESS_SEQUENCER_ACCESS_COUNT_EN
    for (int i = 0; i < 300; i++) begin
      issue(1, 1, 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
      wait_for(1, 0, "cnt_write_done");
    end
    check("count_saturated", 1, 32'(acc_cnt[1]), 32'd255);
    rst = 1;
    @(negedge clk);
    rst = 0;
    check("count_reset", 1, 32'(acc_cnt[1]), 32'd0);
    issue(1, 1, 3'd1, 8'h11);
    wait_for(1, 0, "cnt_one_done");
    check("count_one", 1, 32'(acc_cnt[1]), 32'd1);
    issue(2, 1, 3'd1, 8'h22);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    repeat (20) @(negedge clk);
    check("count_abort", 2, 32'(acc_cnt[2]), 32'd0);
`endif

    // Random traffic on all instances at once; request payload only changes when idle or taken.
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 299) == 0);
      for (int k = 0; k < N; k++) begin
        if (!req_valid[k] || (m_busy[k] && m_t[k] == cyc)) begin
          req_valid[k] = ($urandom_range(0, 2) != 0);
          write_s[k] = 1'($urandom_range(0, 1));
          addr_s[k] = 3'($urandom_range(0, 7));
          wdata_s[k] = 8'($urandom_range(0, 255));
        end
        rsp_ready[k] = ($urandom_range(0, 3) == 0);
      end
    end
    @(negedge clk);
    rst = 0;
    for (int k = 0; k < N; k++) begin
      req_valid[k] = 0;
      rsp_ready[k] = 1;
    end
    repeat (40) @(negedge clk);
    for (int k = 0; k < N; k++) check("drain_idle", k, 32'(req_ready[k]), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
